// File: rtl/cdb_arbiter.sv
// Complete stage: round-robin arbitration of FU results onto the common data bus.
// Results squashed by branch recovery are dropped; the bus output is registered.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int BR_MASK_W = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_FU-1:0]                 fu_done_i,
    input  logic [NUM_FU*64-1:0]              fu_result_i,
    input  logic [NUM_FU*PRF_IDX_W-1:0]       fu_dest_tag_i,
    input  logic [NUM_FU*(ROB_IDX_W+1)-1:0]   fu_rob_idx_i,
    input  logic [NUM_FU*BR_MASK_W-1:0]       fu_br_mask_i,
    input  logic                              rob_br_recovery_i,
    input  logic                              rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0]              rob_br_tag_fix_i,
    output logic [NUM_FU-1:0]                 fu_stall_o,
    output logic                              cdb_valid_o,
    output logic [63:0]                       cdb_result_o,
    output logic [PRF_IDX_W-1:0]              cdb_tag_o,
    output logic [ROB_IDX_W:0]                cdb_rob_idx_o,
    output logic [BR_MASK_W-1:0]              cdb_br_mask_o
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int RW    = ROB_IDX_W + 1;

    logic [63:0]           res  [NUM_FU];
    logic [PRF_IDX_W-1:0]  tag  [NUM_FU];
    logic [RW-1:0]         rob  [NUM_FU];
    logic [BR_MASK_W-1:0]  mask [NUM_FU];

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
        assign res[g]  = fu_result_i[64*g +: 64];
        assign tag[g]  = fu_dest_tag_i[PRF_IDX_W*g +: PRF_IDX_W];
        assign rob[g]  = fu_rob_idx_i[RW*g +: RW];
        assign mask[g] = fu_br_mask_i[BR_MASK_W*g +: BR_MASK_W];
    end

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  rr_nxt;
    logic [PTR_W-1:0]  gidx;
    logic [NUM_FU-1:0] cand;
    logic [NUM_FU-1:0] grant;
    logic              found;
    logic [BR_MASK_W-1:0] sel_mask;

    // Scan starts at rr_ptr; recovery suppresses every grant this cycle.
    always_comb begin
        int idx;
        idx   = 0;
        cand  = '0;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            cand[i] = fu_done_i[i] &
                      ~(rob_br_recovery_i & |(mask[i] & rob_br_tag_fix_i));
        end
        if (!rob_br_recovery_i) begin
            for (int off = 0; off < NUM_FU; off++) begin
                idx = (int'(rr_ptr) + off) % NUM_FU;
                if (!found && cand[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gidx       = PTR_W'(idx);
                end
            end
        end
    end

    assign fu_stall_o = fu_done_i & ~grant;
    assign rr_nxt     = (gidx == PTR_W'(NUM_FU - 1)) ? '0 : gidx + 1'b1;
    assign sel_mask   = rob_br_pred_correct_i ? (mask[gidx] & ~rob_br_tag_fix_i)
                                              : mask[gidx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            cdb_valid_o   <= 1'b0;
            cdb_result_o  <= '0;
            cdb_tag_o     <= '0;
            cdb_rob_idx_o <= '0;
            cdb_br_mask_o <= '0;
        end else if (found) begin
            rr_ptr        <= rr_nxt;
            cdb_valid_o   <= 1'b1;
            cdb_result_o  <= res[gidx];
            cdb_tag_o     <= tag[gidx];
            cdb_rob_idx_o <= rob[gidx];
            cdb_br_mask_o <= sel_mask;
        end else begin
            cdb_valid_o   <= 1'b0;
            cdb_result_o  <= '0;
            cdb_tag_o     <= '0;
            cdb_rob_idx_o <= '0;
            cdb_br_mask_o <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single result, round-robin, squash,
// mask fix, asynchronous reset and idle/wrap boundaries.
module tb_cdb_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    fu_done;
    logic [255:0]  fu_result;
    logic [23:0]   fu_tag;
    logic [23:0]   fu_rob;
    logic [15:0]   fu_mask;
    logic          recovery;
    logic          pred_correct;
    logic [3:0]    tag_fix;
    logic [3:0]    stall;
    logic          cdb_valid;
    logic [63:0]   cdb_result;
    logic [5:0]    cdb_tag;
    logic [5:0]    cdb_rob;
    logic [3:0]    cdb_mask;

    int n_chk  = 0;
    int n_fail = 0;

    cdb_arbiter dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .fu_done_i             (fu_done),
        .fu_result_i           (fu_result),
        .fu_dest_tag_i         (fu_tag),
        .fu_rob_idx_i          (fu_rob),
        .fu_br_mask_i          (fu_mask),
        .rob_br_recovery_i     (recovery),
        .rob_br_pred_correct_i (pred_correct),
        .rob_br_tag_fix_i      (tag_fix),
        .fu_stall_o            (stall),
        .cdb_valid_o           (cdb_valid),
        .cdb_result_o          (cdb_result),
        .cdb_tag_o             (cdb_tag),
        .cdb_rob_idx_o         (cdb_rob),
        .cdb_br_mask_o         (cdb_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [63:0] r,
                          input logic [5:0] t, input logic [5:0] ri,
                          input logic [3:0] m);
        fu_result[64*i +: 64] = r;
        fu_tag[6*i +: 6]      = t;
        fu_rob[6*i +: 6]      = ri;
        fu_mask[4*i +: 4]     = m;
    endtask

    task automatic chk_cdb(input string name, input logic [63:0] r,
                           input logic [5:0] t, input logic [5:0] ri);
        chk({name, "_valid"}, 64'(cdb_valid), 64'd1);
        chk({name, "_result"}, cdb_result, r);
        chk({name, "_tag"}, 64'(cdb_tag), 64'(t));
        chk({name, "_rob"}, 64'(cdb_rob), 64'(ri));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_result", cdb_result, 64'd0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        fu_done      = '0;
        fu_result    = '0;
        fu_tag       = '0;
        fu_rob       = '0;
        fu_mask      = '0;
        recovery     = 1'b0;
        pred_correct = 1'b0;
        tag_fix      = '0;
        #1;
        chk("init_valid", 64'(cdb_valid), 64'd0);
        chk("init_stall", 64'(stall), 64'd0);
        chk("init_mask", 64'(cdb_mask), 64'd0);
        step();
        rst_n = 1'b1;

        // single result from FU0
        set_fu(0, 64'h5, 6'd7, 6'd3, 4'b0000);
        fu_done = 4'b0001;
        #1;
        chk("single_stall", 64'(stall), 64'd0);
        step();
        chk_cdb("single", 64'h5, 6'd7, 6'd3);
        fu_done = 4'b0000;
        step();
        chk("single_drop", 64'(cdb_valid), 64'd0);

        // round robin from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++)
            set_fu(i, 64'h100 + 64'(i), 6'(10 + i), 6'(i + 1), 4'b0000);
        fu_done = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_stall%0d", k), 64'(stall),
                64'(4'b1111 & ~(4'b0001 << (k % 4))));
            step();
            chk_cdb($sformatf("rr%0d", k), 64'h100 + 64'(k % 4),
                    6'(10 + k % 4), 6'(k % 4 + 1));
        end
        // pointer now 1
        fu_done = 4'b0000;
        step();

        // squash FU1 during recovery, FU2 survives
        set_fu(1, 64'hAA1, 6'd21, 6'd5, 4'b0010);
        set_fu(2, 64'hAA2, 6'd22, 6'd6, 4'b0001);
        fu_done  = 4'b0110;
        recovery = 1'b1;
        tag_fix  = 4'b0010;
        #1;
        chk("sq_stall", 64'(stall), 64'b0110);
        step();
        chk("sq_valid", 64'(cdb_valid), 64'd0);
        recovery = 1'b0;
        tag_fix  = 4'b0000;
        set_fu(0, 64'hAA0, 6'd20, 6'd4, 4'b0000);
        fu_done  = 4'b0101;
        #1;
        chk("sq_ptr_stall", 64'(stall), 64'b0001);
        step();
        chk_cdb("sq_fu2", 64'hAA2, 6'd22, 6'd6);
        chk("sq_fu2_mask", 64'(cdb_mask), 64'b0001);
        fu_done = 4'b0001;
        #1;
        chk("sq_fu0_stall", 64'(stall), 64'd0);
        step();
        chk_cdb("sq_fu0", 64'hAA0, 6'd20, 6'd4);
        // pointer now 1

        // mask fix on the granted entry
        set_fu(0, 64'hBB0, 6'd30, 6'd9, 4'b0110);
        fu_done      = 4'b0001;
        pred_correct = 1'b1;
        tag_fix      = 4'b0100;
        step();
        chk("fix_valid", 64'(cdb_valid), 64'd1);
        chk("fix_mask", 64'(cdb_mask), 64'b0010);
        pred_correct = 1'b0;
        tag_fix      = 4'b0000;

        // asynchronous reset mid-broadcast
        set_fu(1, 64'hCC1, 6'd31, 6'd10, 4'b0000);
        fu_done = 4'b0010;
        step();
        chk_cdb("pre_rst", 64'hCC1, 6'd31, 6'd10);
        fu_done = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(cdb_valid), 64'd0);
        chk("async_result", cdb_result, 64'd0);
        step();
        rst_n = 1'b1;
        set_fu(0, 64'hDD0, 6'd40, 6'd11, 4'b0000);
        set_fu(1, 64'hDD1, 6'd41, 6'd12, 4'b0000);
        fu_done = 4'b0011;
        #1;
        chk("post_rst_stall", 64'(stall), 64'b0010);
        step();
        chk_cdb("post_rst", 64'hDD0, 6'd40, 6'd11);

        // FU3 grant brings the pointer to 0 via wrap
        set_fu(3, 64'hEE3, 6'd43, 6'd14, 4'b0000);
        fu_done = 4'b1000;
        step();
        chk_cdb("wrap_a", 64'hEE3, 6'd43, 6'd14);

        // idle cycles
        fu_done = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("idle_stall%0d", c), 64'(stall), 64'd0);
            step();
            chk($sformatf("idle_valid%0d", c), 64'(cdb_valid), 64'd0);
            chk($sformatf("idle_result%0d", c), cdb_result, 64'd0);
        end

        // FU3 alone with pointer 0, then pointer wraps back to 0
        set_fu(3, 64'hFF3, 6'd50, 6'd15, 4'b0000);
        fu_done = 4'b1000;
        #1;
        chk("fu3_stall", 64'(stall), 64'd0);
        step();
        chk_cdb("fu3", 64'hFF3, 6'd50, 6'd15);
        set_fu(0, 64'hFF0, 6'd51, 6'd16, 4'b0000);
        set_fu(1, 64'hFF1, 6'd52, 6'd17, 4'b0000);
        fu_done = 4'b0011;
        #1;
        chk("wrap_stall", 64'(stall), 64'b0010);
        step();
        chk_cdb("wrap_fu0", 64'hFF0, 6'd51, 6'd16);
        fu_done = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
